// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multi-cycle control unit and the datapath/IR side.
//   opcode        IR[31:21], stable from DECODE to the end of the instruction
//   mem_ready     memory completes the current request this cycle
//   mem_read/mem_write, iord, ir_write, pc_write, pc_src, pc_write_cond,
//   reg2loc, alu_src, mem_to_reg, reg_write, alu_op
//                 datapath mux selects and strobes
//   retire        one-cycle pulse on the last cycle of each instruction
//   retired_cnt   wrapping count of completed instructions (CNT_W bits)
//   fault         sticky fault flag
//   fault_code    00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
// Modports: slave = control unit, master = datapath / IR side.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [10:0]      opcode;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             pc_write_cond;
    logic             reg2loc;
    logic             alu_src;
    logic             mem_to_reg;
    logic             reg_write;
    logic [1:0]       alu_op;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             fault;
    logic [1:0]       fault_code;

    modport slave (
        input  opcode, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               pc_write_cond, reg2loc, alu_src, mem_to_reg, reg_write,
               alu_op, retire, retired_cnt, fault, fault_code
    );

    modport master (
        output opcode, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
               pc_write_cond, reg2loc, alu_src, mem_to_reg, reg_write,
               alu_op, retire, retired_cnt, fault, fault_code
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Multi-cycle LEGv8 main control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on mem_ready with a bounded wait counter,
// traps illegal opcodes and memory timeouts into a sticky FAULT state and
// counts retired instructions.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multicycle_control_if.slave (opcode/mem_ready in, controls out);
//          the interface CNT_W must match this module's CNT_W.
// Parameters: MEM_TIMEOUT (1..2^TO_W-1), TO_W, CNT_W, EN_B (1 = decode B).
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16,
    parameter bit EN_B        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.slave   bus
);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_LD, C_ST, C_CBZ, C_B, C_ILL
    } class_t;

    state_t           state, state_n;
    class_t           cls, dec_class;
    logic [TO_W-1:0]  wait_cnt;
    logic [1:0]       fault_code_q, fault_code_n;
    logic [CNT_W-1:0] retired_cnt_q;
    logic             wait_clr;
    logic             timeout;

    // Opcode classification; only consumed while in DECODE.
    always_comb begin
        casez (bus.opcode)
            11'b1??0101?000: dec_class = C_R;
            11'b11111000010: dec_class = C_LD;
            11'b11111000000: dec_class = C_ST;
            11'b10110100???: dec_class = C_CBZ;
            11'b000101?????: dec_class = EN_B ? C_B : C_ILL;
            default:         dec_class = C_ILL;
        endcase
    end

    // Limit reached with no ready this cycle; a ready on the same cycle wins.
    assign timeout = (wait_cnt == TO_W'(MEM_TIMEOUT)) && !bus.mem_ready;

    // Counter restarts whenever a wait state is entered from another state.
    assign wait_clr = (state_n != state) && (state_n == S_FETCH || state_n == S_MEM);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            cls           <= C_ILL;
            wait_cnt      <= '0;
            fault_code_q  <= 2'b00;
            retired_cnt_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                cls <= dec_class;
            if (wait_clr)
                wait_cnt <= '0;
            else if ((state == S_FETCH || state == S_MEM) && !bus.mem_ready)
                wait_cnt <= wait_cnt + TO_W'(1);
            if (state_n == S_FAULT && state != S_FAULT)
                fault_code_q <= fault_code_n;
            if (bus.retire)
                retired_cnt_q <= retired_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n           = state;
        fault_code_n      = 2'b00;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_src        = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.reg2loc       = 1'b0;
        bus.alu_src       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_op        = 2'b00;
        bus.retire        = 1'b0;
        bus.fault         = 1'b0;

        unique case (state)
            S_INIT: state_n = S_FETCH;

            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_n      = S_DECODE;
                end else if (timeout) begin
                    fault_code_n = 2'b10;
                    state_n      = S_FAULT;
                end
            end

            S_DECODE: begin
                bus.reg2loc = (dec_class == C_ST) || (dec_class == C_CBZ);
                case (dec_class)
                    C_ILL: begin
                        fault_code_n = 2'b01;
                        state_n      = S_FAULT;
                    end
                    C_B: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 1'b1;
                        bus.retire   = 1'b1;
                        state_n      = S_FETCH;
                    end
                    default: state_n = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls)
                    C_R: begin
                        bus.alu_op = 2'b10;
                        state_n    = S_WB;
                    end
                    C_CBZ: begin
                        bus.reg2loc       = 1'b1;
                        bus.alu_op        = 2'b01;
                        bus.pc_src        = 1'b1;
                        bus.pc_write_cond = 1'b1;
                        bus.retire        = 1'b1;
                        state_n           = S_FETCH;
                    end
                    default: begin
                        // Only LD and ST reach EXEC besides R and CBZ.
                        bus.alu_src = 1'b1;
                        state_n     = S_MEM;
                    end
                endcase
            end

            S_MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = (cls == C_LD);
                bus.mem_write = (cls == C_ST);
                if (bus.mem_ready) begin
                    if (cls == C_ST) begin
                        bus.retire = 1'b1;
                        state_n    = S_FETCH;
                    end else begin
                        state_n    = S_WB;
                    end
                end else if (timeout) begin
                    fault_code_n = 2'b11;
                    state_n      = S_FAULT;
                end
            end

            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (cls == C_LD);
                bus.retire     = 1'b1;
                state_n        = S_FETCH;
            end

            S_FAULT: bus.fault = 1'b1;

            default: state_n = S_INIT;
        endcase
    end

    assign bus.fault_code  = fault_code_q;
    assign bus.retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_b = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(16)) ifa ();
    multicycle_control_if #(.CNT_W(2))  ifb ();

    multicycle_control #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(16), .EN_B(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    multicycle_control #(.MEM_TIMEOUT(15), .TO_W(4), .CNT_W(2), .EN_B(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb.slave)
    );

    // Packed control view:
    // mr mw io irw pw ps pwc r2l as m2r rw aop[1:0] ret flt fc[1:0]
    logic [16:0] act_a, act_b;
    assign act_a = {ifa.mem_read, ifa.mem_write, ifa.iord, ifa.ir_write, ifa.pc_write,
                    ifa.pc_src, ifa.pc_write_cond, ifa.reg2loc, ifa.alu_src,
                    ifa.mem_to_reg, ifa.reg_write, ifa.alu_op, ifa.retire,
                    ifa.fault, ifa.fault_code};
    assign act_b = {ifb.mem_read, ifb.mem_write, ifb.iord, ifb.ir_write, ifb.pc_write,
                    ifb.pc_src, ifb.pc_write_cond, ifb.reg2loc, ifb.alu_src,
                    ifb.mem_to_reg, ifb.reg_write, ifb.alu_op, ifb.retire,
                    ifb.fault, ifb.fault_code};

    localparam logic [16:0] ZERO     = 17'b0;
    localparam logic [16:0] F_WAIT   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_0_0_00;
    localparam logic [16:0] F_RDY    = 17'b1_0_0_1_1_0_0_0_0_0_0_00_0_0_00;
    localparam logic [16:0] D_R2L    = 17'b0_0_0_0_0_0_0_1_0_0_0_00_0_0_00;
    localparam logic [16:0] D_B      = 17'b0_0_0_0_1_1_0_0_0_0_0_00_1_0_00;
    localparam logic [16:0] E_R      = 17'b0_0_0_0_0_0_0_0_0_0_0_10_0_0_00;
    localparam logic [16:0] E_CBZ    = 17'b0_0_0_0_0_1_1_1_0_0_0_01_1_0_00;
    localparam logic [16:0] E_MEMOP  = 17'b0_0_0_0_0_0_0_0_1_0_0_00_0_0_00;
    localparam logic [16:0] M_LD     = 17'b1_0_1_0_0_0_0_0_0_0_0_00_0_0_00;
    localparam logic [16:0] M_ST     = 17'b0_1_1_0_0_0_0_0_0_0_0_00_0_0_00;
    localparam logic [16:0] M_ST_RDY = 17'b0_1_1_0_0_0_0_0_0_0_0_00_1_0_00;
    localparam logic [16:0] W_R      = 17'b0_0_0_0_0_0_0_0_0_0_1_00_1_0_00;
    localparam logic [16:0] W_LD     = 17'b0_0_0_0_0_0_0_0_0_1_1_00_1_0_00;
    localparam logic [16:0] FLT_01   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_0_1_01;
    localparam logic [16:0] FLT_10   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_0_1_10;
    localparam logic [16:0] FLT_11   = 17'b0_0_0_0_0_0_0_0_0_0_0_00_0_1_11;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_LD  = 11'b11111000010;
    localparam logic [10:0] OP_ST  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ = 11'b10110100101;
    localparam logic [10:0] OP_B   = 11'b00010100000;
    localparam logic [10:0] OP_ILL = 11'b00000000000;

    typedef struct {
        logic [10:0] opcode;
        logic        ready;
        logic [16:0] exp_ctl;
        logic [15:0] exp_cnt;
        string       name;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on dut_a just after the falling edge, then settle.
    task automatic step_a(input logic [10:0] op, input logic rdy);
        @(negedge clk);
        ifa.opcode    = op;
        ifa.mem_ready = rdy;
        #1;
    endtask

    task automatic step_b(input logic [10:0] op, input logic rdy);
        @(negedge clk);
        ifb.opcode    = op;
        ifb.mem_ready = rdy;
        #1;
    endtask

    // Pulse reset for one cycle, release on a falling edge and check INIT.
    task automatic do_reset_a();
        @(negedge clk);
        rst_n         = 1'b0;
        ifa.mem_ready = 1'b0;
        #1;
        check("reset_async_ctl", 32'(act_a), 32'(ZERO));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_ctl", 32'(act_a), 32'(ZERO));
        check("init_cnt", 32'(ifa.retired_cnt), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        ifa.opcode    = OP_ADD;
        ifa.mem_ready = 1'b0;
        ifb.opcode    = OP_ADD;
        ifb.mem_ready = 1'b1;

        vecs[0]  = '{OP_ADD, 1'b1, F_RDY,    16'd0, "add_fetch"};
        vecs[1]  = '{OP_ADD, 1'b1, ZERO,     16'd0, "add_decode"};
        vecs[2]  = '{OP_ADD, 1'b1, E_R,      16'd0, "add_exec"};
        vecs[3]  = '{OP_ADD, 1'b1, W_R,      16'd0, "add_wb"};
        vecs[4]  = '{OP_CBZ, 1'b1, F_RDY,    16'd1, "cbz_fetch"};
        vecs[5]  = '{OP_CBZ, 1'b1, D_R2L,    16'd1, "cbz_decode"};
        vecs[6]  = '{OP_CBZ, 1'b1, E_CBZ,    16'd1, "cbz_exec"};
        vecs[7]  = '{OP_B,   1'b1, F_RDY,    16'd2, "b_fetch"};
        vecs[8]  = '{OP_B,   1'b1, D_B,      16'd2, "b_decode"};
        vecs[9]  = '{OP_LD,  1'b0, F_WAIT,   16'd3, "fetch_wait"};
        vecs[10] = '{OP_LD,  1'b1, F_RDY,    16'd3, "ld_fetch"};
        vecs[11] = '{OP_LD,  1'b1, ZERO,     16'd3, "ld_decode"};
        vecs[12] = '{OP_LD,  1'b1, E_MEMOP,  16'd3, "ld_exec"};
        vecs[13] = '{OP_LD,  1'b0, M_LD,     16'd3, "ld_mem_wait"};

        // ---- Reset state and table-driven sequence ----
        #2;
        check("reset_ctl", 32'(act_a), 32'(ZERO));
        check("reset_cnt", 32'(ifa.retired_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_ctl", 32'(act_a), 32'(ZERO));
        foreach (vecs[i]) begin
            step_a(vecs[i].opcode, vecs[i].ready);
            check({vecs[i].name, "_ctl"}, 32'(act_a), 32'(vecs[i].exp_ctl));
            check({vecs[i].name, "_cnt"}, 32'(ifa.retired_cnt), 32'(vecs[i].exp_cnt));
        end

        // ---- Reset mid-MEM: immediate async clear, then INIT, then FETCH ----
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem_rst_ctl", 32'(act_a), 32'(ZERO));
        check("midmem_rst_cnt", 32'(ifa.retired_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midmem_init_ctl", 32'(act_a), 32'(ZERO));
        step_a(OP_ADD, 1'b0);
        check("midmem_fetch_ctl", 32'(act_a), 32'(F_WAIT));

        // ---- LD with three wait cycles in MEM: 8 cycles ----
        do_reset_a();
        step_a(OP_LD, 1'b1); check("ldw_fetch", 32'(act_a), 32'(F_RDY));
        step_a(OP_LD, 1'b1); check("ldw_decode", 32'(act_a), 32'(ZERO));
        step_a(OP_LD, 1'b1); check("ldw_exec", 32'(act_a), 32'(E_MEMOP));
        for (int i = 0; i < 3; i++) begin
            step_a(OP_LD, 1'b0); check("ldw_mem_wait", 32'(act_a), 32'(M_LD));
        end
        step_a(OP_LD, 1'b1); check("ldw_mem_rdy", 32'(act_a), 32'(M_LD));
        step_a(OP_LD, 1'b1); check("ldw_wb", 32'(act_a), 32'(W_LD));
        check("ldw_wb_cnt", 32'(ifa.retired_cnt), 32'd0);
        step_a(OP_LD, 1'b0); check("ldw_next_fetch", 32'(act_a), 32'(F_WAIT));
        check("ldw_cnt", 32'(ifa.retired_cnt), 32'd1);

        // ---- FETCH timeout: counter reaches 15 after 15 waits, faults next ----
        do_reset_a();
        for (int i = 0; i < 16; i++) begin
            step_a(OP_ADD, 1'b0); check("fto_wait", 32'(act_a), 32'(F_WAIT));
        end
        step_a(OP_ADD, 1'b1); check("fto_fault", 32'(act_a), 32'(FLT_10));
        for (int i = 0; i < 3; i++) begin
            step_a(OP_ADD, 1'b1); check("fto_sticky", 32'(act_a), 32'(FLT_10));
        end

        // ---- Ready on the limit cycle wins ----
        do_reset_a();
        for (int i = 0; i < 15; i++) step_a(OP_ADD, 1'b0);
        step_a(OP_ADD, 1'b1); check("limit_rdy_fetch", 32'(act_a), 32'(F_RDY));
        step_a(OP_ADD, 1'b1); check("limit_rdy_decode", 32'(act_a), 32'(ZERO));
        step_a(OP_ADD, 1'b1); check("limit_rdy_exec", 32'(act_a), 32'(E_R));

        // ---- ST completes, then a second ST times out in MEM ----
        do_reset_a();
        step_a(OP_ST, 1'b1); check("st_fetch", 32'(act_a), 32'(F_RDY));
        step_a(OP_ST, 1'b1); check("st_decode", 32'(act_a), 32'(D_R2L));
        step_a(OP_ST, 1'b1); check("st_exec", 32'(act_a), 32'(E_MEMOP));
        step_a(OP_ST, 1'b1); check("st_mem_rdy", 32'(act_a), 32'(M_ST_RDY));
        step_a(OP_ST, 1'b1); check("st2_fetch", 32'(act_a), 32'(F_RDY));
        check("st_cnt", 32'(ifa.retired_cnt), 32'd1);
        step_a(OP_ST, 1'b1);
        step_a(OP_ST, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step_a(OP_ST, 1'b0); check("mto_wait", 32'(act_a), 32'(M_ST));
        end
        step_a(OP_ST, 1'b1); check("mto_fault", 32'(act_a), 32'(FLT_11));
        check("mto_cnt", 32'(ifa.retired_cnt), 32'd1);

        // ---- Illegal opcode: sticky code 01 ----
        do_reset_a();
        step_a(OP_ILL, 1'b1); check("ill_fetch", 32'(act_a), 32'(F_RDY));
        step_a(OP_ILL, 1'b1); check("ill_decode", 32'(act_a), 32'(ZERO));
        for (int i = 0; i < 4; i++) begin
            step_a(OP_ADD, 1'b1); check("ill_fault", 32'(act_a), 32'(FLT_01));
        end
        do_reset_a();
        step_a(OP_ADD, 1'b1); check("ill_cleared_fetch", 32'(act_a), 32'(F_RDY));

        // ---- dut_b: CNT_W = 2 wrap, then B illegal with EN_B = 0 ----
        @(negedge clk);
        rst_n_b = 1'b1;
        #1;
        check("b_init_ctl", 32'(act_b), 32'(ZERO));
        for (int k = 1; k <= 21; k++) begin
            step_b((k == 21) ? OP_B : OP_ADD, 1'b1);
            if (k == 13) check("wrap_cnt3", 32'(ifb.retired_cnt), 32'd3);
            if (k == 17) check("wrap_cnt0", 32'(ifb.retired_cnt), 32'd0);
            if (k == 20) check("wrap_wb", 32'(act_b), 32'(W_R));
        end
        check("wrap_cnt1", 32'(ifb.retired_cnt), 32'd1);
        check("nob_fetch", 32'(act_b), 32'(F_RDY));
        step_b(OP_B, 1'b1); check("nob_decode", 32'(act_b), 32'(ZERO));
        step_b(OP_B, 1'b1); check("nob_fault", 32'(act_b), 32'(FLT_01));
        check("nob_cnt", 32'(ifb.retired_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle LEGv8 main control unit for the next-generation datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a memory ready handshake with a timeout. Illegal opcodes and timeouts trap into a sticky fault state, and retired instructions are counted. It sits between the instruction register (IR) and the datapath mux/strobe inputs, replacing per-instruction single-cycle decoding.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive cycles spent waiting for mem_ready before faulting (1..2^TO_W-1).
- TO_W, 4: width of the wait counter.
- CNT_W, 16: width of the retired-instruction counter.
- EN_B, 1: 1 = unconditional B is decoded; 0 = B is treated as illegal.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  11  IR[31:21]; must be stable from DECODE to end of instruction.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_read, mem_write  out  1  memory strobes.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write, pc_write  out  1  IR load; unconditional PC load.
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
- pc_write_cond  out  1  CBZ: the datapath loads the branch target if zero.
- reg2loc, alu_src, mem_to_reg, reg_write  out  1  same meaning as the single-cycle signals.
- alu_op  out  2  00 = add, 01 = pass/zero test, 10 = R-type function.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- retired_cnt  out  CNT_W  number of completed instructions; wraps.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 = none, 01 = illegal opcode, 10 = fetch timeout, 11 = data timeout.

## Operation
- Decode classes (X = don't care):
  - R: 1XX0101X000
  - LD: 11111000010
  - ST: 11111000000
  - CBZ: 10110100XXX
  - B: 000101XXXXX, only when EN_B = 1
  - Anything else: ILL
- The class is registered at the end of DECODE and holds until FETCH is re-entered.
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, FAULT. Any output not listed for a state is 0.
- INIT: all outputs 0; go to FETCH next cycle.
- FETCH:
  - Drives mem_read = 1, iord = 0.
  - When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0 (Mealy); go to DECODE.
- DECODE:
  - Drives reg2loc = 1 when the class is ST or CBZ.
  - ILL: go to FAULT with code 01.
  - B: pc_write = 1, pc_src = 1, retire; go to FETCH.
  - Otherwise: go to EXEC.
- EXEC:
  - R: alu_op = 10; go to WB.
  - LD/ST: alu_src = 1, alu_op = 00; go to MEM.
  - CBZ: reg2loc = 1, alu_op = 01, pc_src = 1, pc_write_cond = 1, retire; go to FETCH.
- MEM:
  - Drives iord = 1; mem_read = 1 for LD, mem_write = 1 for ST.
  - When mem_ready = 1: LD goes to WB; ST asserts retire and goes to FETCH.
- WB: reg_write = 1, mem_to_reg = 1 for LD (0 for R), retire; go to FETCH.
- FAULT: all strobes 0; fault = 1; fault_code holds. Only rst_n exits this state.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments every FETCH/MEM cycle in which mem_ready = 0.
  - When the counter equals MEM_TIMEOUT and mem_ready = 0: go to FAULT with code 10 (FETCH) or 11 (MEM).
  - When mem_ready = 1 in the same cycle as the limit is reached, the ready wins and no fault is raised.
- retired_cnt increments on each retire pulse and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert): state = INIT; all outputs 0, including retired_cnt, fault and fault_code.
- Reset deassertion is synchronised by the first clock edge. FETCH begins 1 cycle after reset release.
- Cycles per instruction with mem_ready = 1 on the first cycle of each wait:
  - B: 2
  - CBZ: 3
  - R: 4
  - ST: 4
  - LD: 5
- Every memory wait cycle adds 1 cycle.
- Control outputs are combinational from state, registered class and mem_ready. No output depends on opcode outside DECODE.
- retire falls in the same cycle as the final-state strobe (pc_write, pc_write_cond, reg_write or mem_write).
- Reset asserted mid-instruction aborts it immediately: no retire pulse, and the counter is cleared.

## Test plan
- R-type, opcode 10001011000 (ADD), mem_ready always 1:
  - States FETCH, DECODE, EXEC, WB.
  - alu_op = 10 in EXEC; reg_write = 1 and retire = 1 in cycle 4; retired_cnt = 1.
- LD 11111000010 with mem_ready delayed 3 cycles in MEM: 8 cycles total; mem_read = 1 and iord = 1 for 4 MEM cycles; WB asserts mem_to_reg = 1 and reg_write = 1.
- CBZ 10110100101 then B 00010100000 (EN_B = 1):
  - CBZ: pc_write_cond = 1 and pc_src = 1 in cycle 3.
  - B: pc_write = 1 and pc_src = 1 in DECODE.
  - retired_cnt = 2 after 5 cycles.
- Opcode 00000000000 gives fault_code = 01 and sticky fault = 1. B with EN_B = 0 also gives fault_code 01. No strobes assert until rst_n is pulsed.
- Timeouts, MEM_TIMEOUT = 15:
  - mem_ready held 0 in FETCH: FAULT with code 10 after 15 wait cycles.
  - mem_ready = 1 exactly on wait cycle 15: no fault.
  - ST with no ready in MEM: code 11.
- Reset and counter:
  - rst_n pulsed low mid-MEM: outputs 0 asynchronously; INIT, then FETCH; retired_cnt = 0.
  - CNT_W = 2: after 5 retires, retired_cnt = 1 (wrap).
